uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_core.sv | 158 +++++++++++++++
 tb/tb_uart_rx_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default line parameters and
// the sample-tick divider computation.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    localparam int DEFAULT_CLK_FREQUENCY = 50_000_000;
    localparam int DEFAULT_BAUD          = 9600;
    localparam int DEFAULT_OVERSAMPLE    = 8;

    // CLK cycles per sample tick, rounded to nearest.
    function automatic int calc_div(input int clk_frequency, input int baud, input int oversample);
        longint den;
        den = longint'(baud) * longint'(oversample);
        return int'((longint'(clk_frequency) + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one-cycle pulse every DIV clocks, held in phase 0
// while i_restart is high.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_restart,
    output logic o_tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("uart_baud_tick: DIV must be >= 1");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST || i_restart) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: synchronized RXD, oversampled 3-sample majority vote,
// single-byte holding register with overrun, frame-error and break handling.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = DEFAULT_CLK_FREQUENCY,
    parameter int BAUD          = DEFAULT_BAUD,
    parameter int OVERSAMPLE    = DEFAULT_OVERSAMPLE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    input  logic       RX_CLEAR,
    output logic       RX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_OVERRUN,
    output logic       RX_FRAME_ERR,
    output logic       RX_IDLE
);
    localparam int DIV  = calc_div(CLK_FREQUENCY, BAUD, OVERSAMPLE);
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] SAMP_LO  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] SAMP_MID = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] SAMP_HI  = OS_W'(OVERSAMPLE / 2 + 1);

    generate
        if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_bad_oversample
            $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
        end
    endgenerate

    logic            r_sync1, r_sync2;
    logic [1:0]      r_fill;
    logic            w_rxd, w_rxd_seen;
    rx_state_t       r_state;
    logic            r_armed;
    logic [OS_W-1:0] r_os;
    logic [OS_W-1:0] w_os_inc;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [1:0]      r_samp;
    logic            w_tick, w_restart, w_decide, w_vote;
    logic            r_ready, r_overrun, r_frame_err;
    logic [7:0]      r_data;

    // NOTE: non-blocking assignments let each stage capture the previous stage's old value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_fill  <= 2'b00;
        end else begin
            r_sync1 <= RXD;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
        end
    end

    assign w_rxd = r_sync2;
    // Reset preloads of the synchronizer must not count as having seen the line high.
    assign w_rxd_seen = r_fill[1] && r_sync2;

    assign w_restart = (r_state == S_IDLE);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .CLK      (CLK),
        .RST      (RST),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    assign w_os_inc = (r_os == OS_LAST) ? '0 : r_os + OS_W'(1);
    assign w_decide = w_tick && (w_os_inc == SAMP_HI);
    assign w_vote   = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rxd) | (r_samp[1] & w_rxd);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_os        <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_samp      <= 2'b11;
            r_data      <= 8'h00;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_rxd_seen) begin
                r_armed <= 1'b1;
            end
            if (RX_CLEAR) begin
                r_ready     <= 1'b0;
                r_overrun   <= 1'b0;
                r_frame_err <= 1'b0;
            end
            if (w_tick && (r_state inside {S_START, S_DATA, S_STOP})) begin
                r_os <= w_os_inc;
                if (w_os_inc == SAMP_LO)  r_samp[0] <= w_rxd;
                if (w_os_inc == SAMP_MID) r_samp[1] <= w_rxd;
            end
            case (r_state)
                S_IDLE: begin
                    // Detection already sits a sync delay into the start bit, so the
                    // window phase starts at 1 and the stop vote lands by mid-bit.
                    if (r_armed && !w_rxd) begin
                        r_state <= S_START;
                        r_os    <= OS_W'(1);
                        r_bit   <= 3'd0;
                    end
                end
                S_START: begin
                    if (w_decide) begin
                        r_state <= w_vote ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_vote, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        if (w_vote) begin
                            r_data    <= r_shift;
                            r_ready   <= 1'b1;
                            r_overrun <= (r_ready || r_overrun) && !RX_CLEAR;
                            r_state   <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rxd) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign RX_READY     = r_ready;
    assign RX_DATA      = r_data;
    assign RX_OVERRUN   = r_overrun;
    assign RX_FRAME_ERR = r_frame_err;
    assign RX_IDLE      = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core at 16 CLK per bit: directed 8N1
// scenarios, then random bytes against a byte-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int CLK_PER_BIT = 16;
    localparam int FRAME_CLK   = 10 * CLK_PER_BIT;
    localparam int MAX_LATENCY = 156;
    // Completion edge after the start edge: 2 sync stages, the detect cycle,
    // then the stop vote at sample tick 76 with 2 CLK per tick.
    localparam int COMPLETE_AT = 154;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RXD = 1'b1;
    logic       RX_CLEAR = 1'b0;
    logic       RX_READY;
    logic [7:0] RX_DATA;
    logic       RX_OVERRUN;
    logic       RX_FRAME_ERR;
    logic       RX_IDLE;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int t_start  = 0;

    // Byte-level reference model of the holding register and flags.
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_ovr;
    logic       m_ferr;

    uart_rx_core #(
        .CLK_FREQUENCY(16_000_000),
        .BAUD         (1_000_000),
        .OVERSAMPLE   (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RXD         (RXD),
        .RX_CLEAR    (RX_CLEAR),
        .RX_READY    (RX_READY),
        .RX_DATA     (RX_DATA),
        .RX_OVERRUN  (RX_OVERRUN),
        .RX_FRAME_ERR(RX_FRAME_ERR),
        .RX_IDLE     (RX_IDLE)
    );

    always #5 CLK = ~CLK;

    // Cycle counter and RX_READY rising-edge timestamp.
    initial begin
        logic ready_q;
        ready_q = 1'b0;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (RX_READY && !ready_q) rise_cyc = cyc;
            ready_q = RX_READY;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected $finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit clear_same);
        m_ovr   = clear_same ? 1'b0 : (m_ovr || m_ready);
        m_ferr  = clear_same ? 1'b0 : m_ferr;
        m_ready = 1'b1;
        m_data  = b;
    endtask

    task automatic model_clear();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".data"},  RX_DATA,      m_data);
        check({tag, ".ready"}, RX_READY,     m_ready);
        check({tag, ".ovr"},   RX_OVERRUN,   m_ovr);
        check({tag, ".ferr"},  RX_FRAME_ERR, m_ferr);
    endtask

    // Drives one 8N1 frame; RX_CLEAR pulses for the cycle after negedge clear_at.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int clear_at);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < FRAME_CLK; i++) begin
            @(negedge CLK);
            if (i == 0) t_start = cyc;
            RXD      = bits[i / CLK_PER_BIT];
            RX_CLEAR = (i == clear_at);
        end
        @(negedge CLK);
        RX_CLEAR = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge CLK);
        RX_CLEAR = 1'b1;
        @(negedge CLK);
        RX_CLEAR = 1'b0;
        model_clear();
    endtask

    task automatic check_latency(input string tag);
        check(tag, (rise_cyc > t_start && rise_cyc - t_start <= MAX_LATENCY) ? 1 : 0, 1);
    endtask

    initial begin
        bit         ok;
        logic [7:0] rb;
        int         gap;

        model_reset();
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_state("reset");
        check("reset.idle", RX_IDLE, 1);

        // Two clean bytes, acknowledged after each.
        send_frame(8'hA5, 1'b1, -1);
        model_byte(8'hA5, 1'b0);
        check_latency("a5.latency");
        check_state("a5");
        pulse_clear();
        check("a5.cleared", RX_READY, 0);
        send_frame(8'h3C, 1'b1, -1);
        model_byte(8'h3C, 1'b0);
        check_latency("3c.latency");
        check_state("3c");
        pulse_clear();

        // 4 CLK low glitch in idle is rejected.
        ok = 1'b0;
        @(negedge CLK);
        RXD = 1'b0;
        for (int i = 1; i < 24; i++) begin
            @(negedge CLK);
            if (i == 4) RXD = 1'b1;
            if (!RX_IDLE) ok = 1'b1;
        end
        check("glitch.entered_start", ok, 1);
        check("glitch.back_idle", RX_IDLE, 1);
        check_state("glitch");
        send_frame(8'h55, 1'b1, -1);
        model_byte(8'h55, 1'b0);
        check_state("55");
        pulse_clear();

        // Stop bit low: frame error, break until line high, then recovery.
        send_frame(8'h12, 1'b0, -1);
        m_ferr = 1'b1;
        check_state("ferr");
        repeat (32) @(negedge CLK);
        check("ferr.in_break", RX_IDLE, 0);
        RXD = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (RX_IDLE) begin
                ok = 1'b1;
                break;
            end
        end
        check("ferr.break_exit", ok, 1);
        check("ferr.sticky", RX_FRAME_ERR, 1);
        pulse_clear();
        check_state("ferr.cleared");
        send_frame(8'h34, 1'b1, -1);
        model_byte(8'h34, 1'b0);
        check_state("34");
        pulse_clear();

        // Overrun: second byte without acknowledge.
        send_frame(8'h11, 1'b1, -1);
        model_byte(8'h11, 1'b0);
        send_frame(8'h22, 1'b1, -1);
        model_byte(8'h22, 1'b0);
        check_state("overrun");
        pulse_clear();
        check_state("overrun.cleared");

        // Reset during bit 3 of 0xFF, then the line held low for 40 CLK.
        @(negedge CLK);
        RXD = 1'b0;
        repeat (CLK_PER_BIT - 1) @(negedge CLK);
        RXD = 1'b1;
        repeat (3 * CLK_PER_BIT + 8) @(negedge CLK);
        RST = 1'b1;
        RXD = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        ok = 1'b1;
        for (int i = 0; i < 38; i++) begin
            @(negedge CLK);
            if (!RX_IDLE || RX_READY) ok = 1'b0;
        end
        check("rst_mid.stayed_idle", ok, 1);
        check_state("rst_mid");
        RXD = 1'b1;
        repeat (8) @(negedge CLK);
        send_frame(8'h81, 1'b1, -1);
        model_byte(8'h81, 1'b0);
        check_state("81");
        pulse_clear();

        // Acknowledge on the exact completion cycle of a byte with one pending.
        send_frame(8'h77, 1'b1, -1);
        model_byte(8'h77, 1'b0);
        check_state("77");
        send_frame(8'h66, 1'b1, COMPLETE_AT);
        model_byte(8'h66, 1'b1);
        check_state("clear_on_done");
        pulse_clear();

        // Random bytes, random idle gaps and random acknowledges.
        for (int n = 0; n < 8; n++) begin
            rb  = 8'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 20));
            repeat (gap) @(negedge CLK);
            send_frame(rb, 1'b1, -1);
            model_byte(rb, 1'b0);
            check_state($sformatf("rand%0d", n));
            if ($urandom_range(0, 1) == 1) begin
                pulse_clear();
                check($sformatf("rand%0d.cleared", n), RX_READY, m_ready);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
